// File: rtl/philv_mem_loader_if.sv
// Byte-stream input and memory write port of the Philosophy-V program loader.
// master: stream source / memory side; slave: the loader itself.
interface philv_mem_loader_if #(
    parameter int unsigned BUS_WIDTH = 32
);
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 mem_wr_ena;
    logic [BUS_WIDTH-1:0] mem_addr;
    logic [BUS_WIDTH-1:0] mem_din;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_wr_ena,
        input  mem_addr,
        input  mem_din
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_wr_ena,
        output mem_addr,
        output mem_din
    );
endinterface

// File: rtl/philv_mem_loader.sv
// Program loader: assembles a little-endian byte stream (header N, then 4*N bytes)
// into 32-bit words, writes them to memory and holds the core in reset until done.
module philv_mem_loader #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned WORDS     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start_i,
    philv_mem_loader_if.slave bus_if,
    output logic              core_rstb_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int unsigned CntW = $clog2(WORDS + 1);

    typedef enum logic [2:0] {StIdle, StLen, StData, StWrite, StDone, StErr} state_e;

    state_e               state_q;
    logic [1:0]           byte_cnt_q;
    logic [CntW-1:0]      word_cnt_q;
    logic [BUS_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0] len_q;
    logic [BUS_WIDTH-1:0] asm_q;
    logic                 in_ready_q;
    logic                 wr_ena_q;
    logic                 core_rstb_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;

    logic [BUS_WIDTH-1:0] asm_shift;
    logic [CntW-1:0]      word_cnt_inc;

    // Little-endian assembly: each new byte enters at the top and earlier bytes move down.
    assign asm_shift    = {bus_if.in_data, asm_q[BUS_WIDTH-1:8]};
    assign word_cnt_inc = word_cnt_q + CntW'(1);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            addr_q      <= BUS_WIDTH'(BASE_ADDR);
            len_q       <= '0;
            asm_q       <= '0;
            in_ready_q  <= 1'b0;
            wr_ena_q    <= 1'b0;
            core_rstb_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ena_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start_i) begin
                        state_q     <= StLen;
                        byte_cnt_q  <= '0;
                        word_cnt_q  <= '0;
                        addr_q      <= BUS_WIDTH'(BASE_ADDR);
                        in_ready_q  <= 1'b1;
                        core_rstb_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                StLen: begin
                    if (bus_if.in_valid) begin
                        asm_q      <= asm_shift;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            len_q <= asm_shift;
                            if (asm_shift == '0) begin
                                state_q     <= StDone;
                                in_ready_q  <= 1'b0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                core_rstb_q <= 1'b1;
                            end else if (asm_shift > BUS_WIDTH'(WORDS)) begin
                                state_q    <= StErr;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                                error_q    <= 1'b1;
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (bus_if.in_valid) begin
                        asm_q      <= asm_shift;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q    <= StWrite;
                            in_ready_q <= 1'b0;
                            wr_ena_q   <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    addr_q     <= addr_q + BUS_WIDTH'(4);
                    word_cnt_q <= word_cnt_inc;
                    if (BUS_WIDTH'(word_cnt_inc) == len_q) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        core_rstb_q <= 1'b1;
                    end else begin
                        state_q    <= StData;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_if.in_ready   = in_ready_q;
    assign bus_if.mem_wr_ena = wr_ena_q;
    assign bus_if.mem_addr   = addr_q;
    assign bus_if.mem_din    = asm_q;
    assign core_rstb_o       = core_rstb_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign error_o           = error_q;

endmodule

// File: tb/tb_philv_mem_loader.sv
// Scoreboard bench for philv_mem_loader: expected writes come from a byte-level
// model of the stream format and are checked by an independent write monitor.
module tb_philv_mem_loader;

    localparam int unsigned WORDS = 256;
    localparam logic [31:0] BASE  = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic start = 1'b0;
    logic core_rstb, busy, done, error;

    int errors = 0;
    int checks = 0;

    wr_t         exp_q[$];
    logic [7:0]  stream[$];
    logic        prev_wr = 1'b0;

    philv_mem_loader_if #(.BUS_WIDTH(32)) bus ();

    philv_mem_loader #(
        .BUS_WIDTH(32),
        .WORDS    (WORDS),
        .BASE_ADDR(0)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .start_i    (start),
        .bus_if     (bus.slave),
        .core_rstb_o(core_rstb),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rstb && bus.mem_wr_ena === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write",
                         bus.mem_addr, bus.mem_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_din !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             bus.mem_addr, bus.mem_din, e.addr, e.data);
                end
            end
            chk("wr_not_back_to_back", {31'b0, prev_wr}, 32'd0);
            chk("in_ready_low_in_write", {31'b0, bus.in_ready}, 32'd0);
        end
        prev_wr <= rstb & bus.mem_wr_ena;
    end

    // Reference model: header is word 0 of the stream, data word i is bytes 4+4i..7+4i.
    task automatic model_load();
        logic [31:0] n;
        n = {stream[3], stream[2], stream[1], stream[0]};
        if (n != 0 && n <= WORDS) begin
            for (int i = 0; i < int'(n); i++) begin
                wr_t e;
                e.addr = BASE + 32'(4 * i);
                e.data = {stream[4*i+7], stream[4*i+6], stream[4*i+5], stream[4*i+4]};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic build(input logic [31:0] n, input int ndata);
        stream.delete();
        for (int i = 0; i < 4; i++) stream.push_back(n[8*i +: 8]);
        for (int i = 0; i < 4 * ndata; i++) stream.push_back(8'($urandom));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("after_start_busy", {31'b0, busy}, 32'd1);
        chk("after_start_core_rstb", {31'b0, core_rstb}, 32'd0);
        chk("after_start_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("after_start_done", {31'b0, done}, 32'd0);
    endtask

    // Called and returns at posedge+1; returns once the byte has transferred.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit acc;
        int budget;
        while ($urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        budget = 0;
        acc = 1'b0;
        while (!acc) begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            budget++;
            if (!acc && budget > 200) begin
                errors++;
                checks++;
                $display("FAIL byte_accept_timeout: in_ready stayed %b, expected 1", bus.in_ready);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input int gap_pct, input int start_idx, input int count);
        for (int i = 0; i < count; i++) begin
            if (i == start_idx) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            send_byte(stream[i], gap_pct);
        end
    endtask

    // Checks the end-of-load outputs with cycle-exact timing after the final byte.
    task automatic finish_check();
        logic [31:0] n;
        n = {stream[3], stream[2], stream[1], stream[0]};
        if (n == 0 || n > WORDS) begin
            chk("hdr_end_done", {31'b0, done}, (n == 0) ? 32'd1 : 32'd0);
            chk("hdr_end_error", {31'b0, error}, (n == 0) ? 32'd0 : 32'd1);
            chk("hdr_end_core_rstb", {31'b0, core_rstb}, (n == 0) ? 32'd1 : 32'd0);
            chk("hdr_end_busy", {31'b0, busy}, 32'd0);
        end else begin
            chk("last_write_done_low", {31'b0, done}, 32'd0);
            chk("last_write_strobe", {31'b0, bus.mem_wr_ena}, 32'd1);
            @(posedge clk); #1;
            chk("load_done", {31'b0, done}, 32'd1);
            chk("load_core_rstb", {31'b0, core_rstb}, 32'd1);
            chk("load_busy", {31'b0, busy}, 32'd0);
            chk("load_error", {31'b0, error}, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_load(input int gap_pct, input int start_idx);
        do_start();
        model_load();
        send_stream(gap_pct, start_idx, stream.size());
        finish_check();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("rst_wr_ena", {31'b0, bus.mem_wr_ena}, 32'd0);
        chk("rst_addr", bus.mem_addr, BASE);
        chk("rst_din", bus.mem_din, 32'd0);
        chk("rst_core_rstb", {31'b0, core_rstb}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        rstb = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_core_rstb", {31'b0, core_rstb}, 32'd0);
        chk("idle_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Basic two-word load
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00};
        run_load(0, -1);

        // Empty image
        build(32'd0, 0);
        run_load(0, -1);

        // Oversize header, then a 1-word load recovers
        build(32'(WORDS + 1), 0);
        run_load(0, -1);
        build(32'd1, 1);
        run_load(0, -1);

        // Backpressure plus ignored start mid-data
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00};
        run_load(50, 6);

        // Reset after two bytes of the first data word
        build(32'd2, 2);
        do_start();
        send_stream(0, -1, 6);
        #3 rstb = 1'b0;
        #1;
        chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_din", bus.mem_din, 32'd0);
        chk("midrst_addr", bus.mem_addr, BASE);
        chk("midrst_core_rstb", {31'b0, core_rstb}, 32'd0);
        @(posedge clk); #1;
        rstb = 1'b1;
        @(posedge clk); #1;
        build(32'd2, 2);
        run_load(0, -1);

        // Randomised loads with random gaps and stray starts
        for (int r = 0; r < 5; r++) begin
            int n;
            n = int'($urandom_range(6, 1));
            build(32'(n), n);
            run_load(int'($urandom_range(60)), ($urandom_range(1) == 1) ? 4 + int'($urandom_range(4 * n - 1)) : -1);
        end

        // Full capacity is legal
        build(32'(WORDS), WORDS);
        run_load(0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
